// File: rtl/minibus_pkg.sv
// Mini-bus shared definitions.
// Bus geometry used by initiators and slaves.
package minibus_pkg;

  parameter int ADDR_WIDTH = 32;
  parameter int DATA_WIDTH = 32;

endpackage

// File: rtl/minibus_master_port.sv
// Mini-bus initiator: one CPU load/store -> one bus transaction.
// Optional REQ timeout enabled by MINIBUS_MASTER_TIMEOUT_EN.
module minibus_master_port
  import minibus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int AW             = minibus_pkg::ADDR_WIDTH,
  parameter int DW             = minibus_pkg::DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic          cpu_wen,
  input  logic          cpu_signed,
  input  logic [1:0]    cpu_width,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          bus_wen,
  output logic          bus_ren,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [1:0]    bus_width,
  input  logic          bus_ack,
  input  logic          bus_err,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_wen;
  logic          r_signed;
  logic          r_first;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_bus_wen;
  logic          r_bus_ren;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_width;

  logic          w_lerr;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_ext;

  assign w_lerr = (cpu_width == 2'b11)
                | ((cpu_width == 2'b01) & cpu_addr[0])
                | ((cpu_width == 2'b10) & (|cpu_addr[1:0]));

  // Slaves return the whole aligned word; pick the addressed lane.
  assign w_byte = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = bus_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = bus_rdata;
    unique case (r_width)
      2'b00:   w_ext = {{(DW-8){r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{(DW-16){r_signed & w_half[15]}}, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

`ifdef MINIBUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          w_tmo;
  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wen       <= 1'b0;
      r_signed    <= 1'b0;
      r_first     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_bus_wen   <= 1'b0;
      r_bus_ren   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_width     <= 2'b00;
`ifdef MINIBUS_MASTER_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (cpu_valid) begin
            r_addr   <= cpu_addr;
            r_wdata  <= cpu_wdata;
            r_width  <= cpu_width;
            r_wen    <= cpu_wen;
            r_signed <= cpu_signed;
            if (w_lerr) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= S_TURN;
            end else begin
              r_bus_wen <= cpu_wen;
              r_bus_ren <= ~cpu_wen;
              r_first   <= 1'b1;
              r_state   <= S_REQ;
`ifdef MINIBUS_MASTER_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end
        S_REQ: begin
          r_first <= 1'b0;
          // First REQ cycle ack is stale: the slave registers its ready.
          if (bus_ack && !r_first) begin
            r_bus_wen   <= 1'b0;
            r_bus_ren   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus_err;
            r_rsp_rdata <= (bus_err | r_wen) ? '0 : w_ext;
            r_state     <= S_TURN;
          end
`ifdef MINIBUS_MASTER_TIMEOUT_EN
          else if (w_tmo) begin
            r_bus_wen   <= 1'b0;
            r_bus_ren   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_TURN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_TURN:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign bus_wen   = r_bus_wen;
  assign bus_ren   = r_bus_ren;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_width = r_width;

endmodule
